// File: rtl/data_ram_responder.sv
// Data RAM responder: byte/half/word access with lane extraction and sign/zero extension, plus
// access counters and a registered debug port. Define DATA_RAM_CLEAR_EN for the post-reset clear sweep.
module data_ram_responder #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-3:0] ram_addr,
  input  logic [31:0]          ram_data_in,
  input  logic [3:0]           ram_sel,
  input  logic                 ram_rw,
  input  logic                 ram_extend_type,
  output logic [31:0]          ram_data_out,
  input  logic [ADDR_BITS-3:0] dbg_addr,
  output logic [31:0]          dbg_data,
  output logic                 busy,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic                 sel_err
);

  localparam int unsigned WordAw = ADDR_BITS - 2;
  localparam int unsigned Depth  = 1 << WordAw;

  logic [31:0] mem_q [Depth];

  logic        sel_legal, sel_byte, sel_half;
  logic [31:0] rd_word, rd_ext, lane_mask, wdata_rep, merged;
  logic        cpu_we, mem_we;
  logic [WordAw-1:0] mem_waddr;
  logic [31:0] mem_wdata;

  logic [31:0] rd_count_d, rd_count_q;
  logic [31:0] wr_count_d, wr_count_q;
  logic [31:0] dbg_data_d, dbg_data_q;
  logic        sel_err_d, sel_err_q;
  logic        busy_q;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  always_comb begin
    sel_legal = 1'b1;
    sel_byte  = 1'b0;
    sel_half  = 1'b0;
    case (ram_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_byte = 1'b1;
      4'b0011, 4'b1100:                   sel_half = 1'b1;
      4'b1111:                            sel_legal = 1'b1;
      default:                            sel_legal = 1'b0;
    endcase
  end

  assign rd_word = mem_q[ram_addr];

  always_comb begin
    rd_ext = '0;
    case (ram_sel)
      4'b0001: rd_ext = ext8(rd_word[7:0], ram_extend_type);
      4'b0010: rd_ext = ext8(rd_word[15:8], ram_extend_type);
      4'b0100: rd_ext = ext8(rd_word[23:16], ram_extend_type);
      4'b1000: rd_ext = ext8(rd_word[31:24], ram_extend_type);
      4'b0011: rd_ext = ext16(rd_word[15:0], ram_extend_type);
      4'b1100: rd_ext = ext16(rd_word[31:16], ram_extend_type);
      4'b1111: rd_ext = rd_word;
      default: rd_ext = '0;
    endcase
  end

  // Pre-write contents are returned even on a write cycle.
  assign ram_data_out = (busy_q || !sel_legal) ? 32'h0 : rd_ext;

  // Replicate narrow write data across lanes so the enable mask alone selects the target lane.
  always_comb begin
    lane_mask = {{8{ram_sel[3]}}, {8{ram_sel[2]}}, {8{ram_sel[1]}}, {8{ram_sel[0]}}};
    if (sel_byte) begin
      wdata_rep = {4{ram_data_in[7:0]}};
    end else if (sel_half) begin
      wdata_rep = {2{ram_data_in[15:0]}};
    end else begin
      wdata_rep = ram_data_in;
    end
    merged = (rd_word & ~lane_mask) | (wdata_rep & lane_mask);
    cpu_we = rst & ~busy_q & ram_rw & sel_legal;
  end

`ifdef DATA_RAM_CLEAR_EN
  typedef enum logic {StClear, StRun} state_e;

  state_e            state_d, state_q;
  logic [WordAw-1:0] ptr_d, ptr_q;
  logic              busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
    busy_d = (state_d == StClear);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    if (busy_q) begin
      mem_we    = rst;
      mem_waddr = ptr_q;
      mem_wdata = 32'h0;
    end else begin
      mem_we    = cpu_we;
      mem_waddr = ram_addr;
      mem_wdata = merged;
    end
  end
`else
  assign busy_q    = 1'b0;
  assign mem_we    = cpu_we;
  assign mem_waddr = ram_addr;
  assign mem_wdata = merged;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    sel_err_d  = sel_err_q;
    dbg_data_d = mem_q[dbg_addr];
    if (!busy_q) begin
      if (!sel_legal) begin
        sel_err_d = 1'b1;
      end else if (ram_rw) begin
        wr_count_d = wr_count_q + 32'd1;
      end else begin
        rd_count_d = rd_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      sel_err_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      sel_err_q  <= sel_err_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign busy     = busy_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign sel_err  = sel_err_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Data-memory responder on the CPU's RAM interface: accepts word address, byte-select, read/write and extend-type from the MEM stage and returns lane-extracted, sign/zero-extended read data the same cycle. Writes commit on the clock edge with per-lane byte enables. Optional post-reset clear sweep, access counters and a registered debug read port for the display/inspection logic. Sits beside the CPU in the top level, opposite the CPU's `ram_*` ports.

## Interface
- ADDR_BITS, 12, byte-address width; word array depth = 2^(ADDR_BITS-2)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- ram_addr  in  ADDR_BITS-2  word address from CPU
- ram_data_in  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
- ram_sel  in  4  byte-lane enables; bit i = byte lane i ([8i+7:8i])
- ram_rw  in  1  1 = write, 0 = read
- ram_extend_type  in  1  1 = sign-extend read, 0 = zero-extend
- ram_data_out  out  32  read data, combinational
- dbg_addr  in  ADDR_BITS-2  debug word address
- dbg_data  out  32  registered full word at dbg_addr
- busy  out  1  clear sweep in progress; top level gates CPU `go`/PC with it
- rd_count  out  32  completed read cycles
- wr_count  out  32  committed write cycles
- sel_err  out  1  sticky: illegal ram_sel seen

## Operation
- Legal ram_sel: byte 0001/0010/0100/1000; half 0011/1100; word 1111. Anything else (incl. 0000) illegal.
- Read (ram_rw=0, busy=0): selected byte/half shifted to bit 0, then extended per ram_extend_type; word returned unchanged. Illegal sel -> ram_data_out = 0, sel_err set.
- Write (ram_rw=1, busy=0, legal sel): byte data_in[7:0] replicated into the enabled lane; half data_in[15:0] into lanes 1:0 or 3:2; word whole. Unenabled lanes unchanged. Illegal sel -> no write, sel_err set.
- ram_data_out during a write cycle = extracted current (pre-write) contents.
- Counters: rd_count +1 per clock with busy=0, ram_rw=0, legal sel; wr_count +1 per committed write. Both wrap 0xFFFFFFFF -> 0.
- dbg_data: registered read of dbg_addr; read-before-write on address collision with CPU write.
- Clear FSM (macro on): states CLEAR, RUN. Reset -> CLEAR, ptr=0. CLEAR writes 0 to word ptr, ptr+1 each clock; at ptr = depth-1 write then -> RUN. busy=1 exactly in CLEAR. During CLEAR CPU writes ignored, ram_data_out = 0, counters frozen, sel_err not updated.
- Reset asserted mid-sweep: ptr returns to 0, sweep restarts.

## Timing
- Reset values (cycle after rst=0 edge): dbg_data=0, rd_count=0, wr_count=0, sel_err=0, busy=1 (macro on) / 0 (off). Memory contents not reset by rst itself.
- Read latency 0 (combinational through array); write visible to ram_data_out the cycle after commit edge.
- dbg_data latency 1 cycle.
- Clear sweep: 2^(ADDR_BITS-2) cycles after reset release; busy falls on the edge completing the last word (1024 cycles at default).

## Configuration
- DATA_RAM_CLEAR_EN defined: clear FSM compiled in as above.
- Not defined: no FSM, no ptr; busy tied 0; memory starts with simulator/initial contents (X in sim); CPU access allowed first cycle after reset release.

## Test plan
- Reset, DATA_RAM_CLEAR_EN on, ADDR_BITS=12 -> busy high 1024 cycles then low; dbg read of addr 0x3FF = 0x00000000.
- Write word 0x8091A2B3 to addr 5 (sel 1111), read sel 0100 extend=1 -> 0xFFFFFF91; extend=0 -> 0x00000091.
- Write byte 0x7E sel 0010 to addr 5, then word read -> 0x80917EB3; half read sel 1100 extend=1 -> 0xFFFF8091.
- Write with sel 0101 to addr 6 holding 0x11111111 -> contents unchanged, sel_err=1, wr_count unchanged; sel_err stays 1 until reset.
- Same cycle: CPU write 0xDEADBEEF to addr 9 (old 0x12345678), dbg_addr=9 -> dbg_data next cycle 0x12345678; following cycle 0xDEADBEEF.
- Assert rst for one cycle at sweep ptr 500 -> sweep restarts, busy stays high 1024 further cycles; rd_count/wr_count = 0.
